// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helper and
// the default 10 MHz / 9600 baud / 7-bit link settings used by rx and tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Rounded to the nearest whole clock so the bit-centre error stays below half a cycle
  function automatic int unsigned calc_clk_div(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int unsigned DEF_CLK_HZ    = 10_000_000;
  localparam int unsigned DEF_BAUD      = 9600;
  localparam int unsigned DEF_DATA_BITS = 7;
  localparam int unsigned DEF_CLK_DIV   = calc_clk_div(DEF_CLK_HZ, DEF_BAUD);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, with a selectable reset level
// so idle-high lines do not show a false edge when reset releases.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery with a valid/ready output
// and one-cycle framing-error and overrun pulses.
//
//   state | meaning
//   IDLE  | line idle, waiting for a high-to-low edge
//   START | half-bit wait, then confirm start bit is still low
//   DATA  | sample one data bit every CLK_DIV cycles, LSB first
//   STOP  | sample stop bit, deliver word or flag framing error
//   BREAK | line held low after a bad stop bit, wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_sync;
  logic                 rx_hist;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tc;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (uart_rx_i),
    .q   (rx_sync)
  );

  assign tc = (cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rx_hist     <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_hist     <= rx_sync;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          // history resets low, so the line must be seen high before a start counts
          if (rx_hist && !rx_sync) begin
            state <= START;
            cnt   <= HALF_LD;
          end
        end
        START: begin
          if (!tc) cnt <= cnt - 1'b1;
          else if (!rx_sync) begin
            state   <= DATA;
            cnt     <= FULL_LD;
            bit_cnt <= LAST_BIT;
          end else state <= IDLE;
        end
        DATA: begin
          if (!tc) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            cnt   <= FULL_LD;
            if (bit_cnt == '0) state <= STOP;
            else bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (!tc) cnt <= cnt - 1'b1;
          else if (rx_sync) begin
            state <= IDLE;
            if (!valid_o || ready_i) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end else overrun_o <= 1'b1;
          end else begin
            frame_err_o <= 1'b1;
            state       <= BREAK;
          end
        end
        BREAK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a short bit period; a monitor pops the
// expected-word scoreboard on every accepted word and counts error pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C  = 16;
  localparam int DB = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic [DB-1:0] data;
  logic          valid, ferr, ovr;

  always #50 clk = ~clk;

  uart_rx #(.CLK_DIV(C), .DATA_BITS(DB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .uart_rx_i   (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  int total = 0, bad = 0;
  int n_acc = 0, n_ferr = 0, n_ovr = 0;
  logic [DB-1:0] sb[$];
  logic prev_ferr = 1'b0, prev_ovr = 1'b0;

  typedef struct {
    logic [DB-1:0] d;
    logic          stop_ok;
    int            exp_ferr;
    int            exp_acc;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        n_acc++;
        check("word_pending", sb.size() > 0, 1);
        if (sb.size() > 0) check("rx_data", data, sb.pop_front());
      end
      if (ferr) begin
        n_ferr++;
        check("ferr_width", prev_ferr, 0);
      end
      if (ovr) begin
        n_ovr++;
        check("ovr_width", prev_ovr, 0);
      end
      prev_ferr = ferr;
      prev_ovr  = ovr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int stop_bits);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      tick(C);
    end
    rx = stop;
    tick(C * stop_bits);
    if (!stop) begin
      rx = 1'b1;
      tick(C);
    end
  endtask

  int lat, a0, f0, o0;
  logic [DB-1:0] mid;

  initial begin
    vt = '{'{7'h7F, 1'b0, 1, 0}, '{7'h12, 1'b1, 0, 1}, '{7'h00, 1'b0, 1, 0},
           '{7'h2A, 1'b1, 0, 1}, '{7'h7F, 1'b1, 0, 1}, '{7'h01, 1'b0, 1, 0}};

    // reset values
    tick(3);
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    check("rst_state", dut.state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2 * C);

    // pin-fall to valid latency, first frame of the 0x00..0x1F burst
    sb.push_back('0);
    lat = 0;
    fork
      send_frame('0, 1'b1, 1);
      begin
        do begin
          @(posedge clk); #1;
          lat++;
        end while (!valid && lat < 4 * DB * C);
      end
    join
    check("latency", lat, 2 + C / 2 + (DB + 1) * C + 1);

    for (int i = 1; i < 32; i++) begin
      sb.push_back(DB'(i));
      send_frame(DB'(i), 1'b1, 1);
    end
    tick(4);
    check("burst_acc", n_acc, 32);
    check("burst_ferr", n_ferr, 0);
    check("burst_ovr", n_ovr, 0);
    check("burst_sb_empty", sb.size(), 0);

    // overrun: second word dropped while first still pending
    ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    sb.push_back(7'h55);
    send_frame(7'h55, 1'b1, 1);
    send_frame(7'h2A, 1'b1, 1);
    tick(2);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 7'h55);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_no_acc", n_acc - a0, 0);
    ready = 1'b1;
    tick(1);
    check("ovr_valid_drop", valid, 0);
    check("ovr_acc", n_acc - a0, 1);

    // framing errors mixed with good frames
    for (int i = 0; i < 6; i++) begin
      a0 = n_acc; f0 = n_ferr;
      if (vt[i].stop_ok) sb.push_back(vt[i].d);
      send_frame(vt[i].d, vt[i].stop_ok, vt[i].stop_ok ? 1 : 2);
      tick(2);
      check("tbl_ferr", n_ferr - f0, vt[i].exp_ferr);
      check("tbl_acc", n_acc - a0, vt[i].exp_acc);
    end
    check("tbl_sb_empty", sb.size(), 0);

    // 300 ns glitch on idle line
    a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * C);
    check("glitch_acc", n_acc - a0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_ovr", n_ovr - o0, 0);
    check("glitch_valid", valid, 0);
    check("glitch_state", dut.state, IDLE);

    // line low across reset release
    rst = 1'b1;
    rx = 1'b0;
    tick(3);
    @(negedge clk);
    check("lowrst_data", data, 0);
    check("lowrst_valid", valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * C);
    a0 = n_acc; f0 = n_ferr;
    sb.push_back(7'h33);
    send_frame(7'h33, 1'b1, 1);
    tick(2);
    check("lowrst_acc", n_acc - a0, 1);
    check("lowrst_ferr", n_ferr - f0, 0);
    check("lowrst_sb_empty", sb.size(), 0);

    // reset during data bit 3
    mid = 7'h5A;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      rx = mid[i];
      tick(C);
    end
    rx = mid[3];
    tick(C / 2);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovr", ovr, 0);
    check("midrst_state", dut.state, IDLE);
    @(posedge clk); #1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2 * C);
    a0 = n_acc; f0 = n_ferr;
    sb.push_back(7'h41);
    send_frame(7'h41, 1'b1, 1);
    tick(2);
    check("midrst_acc", n_acc - a0, 1);
    check("midrst_ferr_after", n_ferr - f0, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
